// File: rtl/thiele_cpu.sv
// Multi-cycle 32-bit Thiele machine core: XOR-algebra compute ops, partition/MDL
// accounting and request/acknowledge handshakes to the logic and Python engines.
module thiele_cpu #(
    parameter int NUM_REGS     = 32,
    parameter int MEM_WORDS    = 256,
    parameter int MAX_MODULES  = 64,
    parameter int REGION_SLOTS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_data,
    output logic [31:0] pc,
    output logic [31:0] cert_addr,
    output logic [31:0] status,
    output logic [31:0] error_code,
    output logic [31:0] partition_ops,
    output logic [31:0] mdl_ops,
    output logic [31:0] info_gain,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_en,
    input  logic [31:0] mem_rdata,
    output logic        logic_req,
    output logic [31:0] logic_addr,
    input  logic        logic_ack,
    input  logic [31:0] logic_data,
    output logic        py_req,
    output logic [31:0] py_code_addr,
    input  logic        py_ack,
    input  logic [31:0] py_result
);

    localparam logic [7:0] OP_PNEW     = 8'h01;
    localparam logic [7:0] OP_LASSERT  = 8'h03;
    localparam logic [7:0] OP_MDLACC   = 8'h05;
    localparam logic [7:0] OP_XFER     = 8'h07;
    localparam logic [7:0] OP_PYEXEC   = 8'h08;
    localparam logic [7:0] OP_XOR_LOAD = 8'h0A;
    localparam logic [7:0] OP_XOR_ADD  = 8'h0B;
    localparam logic [7:0] OP_XOR_SWAP = 8'h0C;
    localparam logic [7:0] OP_XOR_RANK = 8'h0D;
    localparam logic [7:0] OP_HALT     = 8'hFF;

    typedef enum logic [2:0] {
        FETCH,
        EXECUTE,
        WAIT_LOGIC,
        WAIT_PY,
        HALTED
    } state_t;

    state_t state;
    state_t next_state;

    logic [31:0] reg_file     [NUM_REGS];
    logic [31:0] data_mem     [MEM_WORDS];
    logic [31:0] module_table [MAX_MODULES];
    logic [31:0] region_table [MAX_MODULES][REGION_SLOTS];

    logic [31:0] instr;
    logic [6:0]  next_module_id;
    logic        error_flag;

    logic [7:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  cost;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [5:0]  mod_idx;
    logic        table_full;
    logic        op_legal;

    assign op      = instr[31:24];
    assign a       = instr[23:16];
    assign b       = instr[15:8];
    assign cost    = instr[7:0];
    assign ra      = a[4:0];
    assign rb      = b[4:0];
    assign mod_idx = next_module_id[5:0];

    assign table_full = (next_module_id >= 7'(MAX_MODULES));

    // The legacy memory port is retired; data memory lives inside the core.
    assign mem_addr  = '0;
    assign mem_wdata = '0;
    assign mem_we    = 1'b0;
    assign mem_en    = 1'b0;

    logic unused_ok;
    assign unused_ok = ^mem_rdata;

    assign status = {29'b0,
                     (state == WAIT_LOGIC) || (state == WAIT_PY),
                     error_flag,
                     state == HALTED};

    function automatic logic [31:0] popcount(input logic [31:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

    always_comb begin
        op_legal = 1'b0;
        case (op)
            OP_XOR_LOAD, OP_XOR_ADD, OP_XOR_SWAP, OP_XFER, OP_XOR_RANK,
            OP_MDLACC, OP_LASSERT, OP_PYEXEC, OP_HALT: op_legal = 1'b1;
            OP_PNEW: op_legal = !table_full;
            default: op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH: next_state = EXECUTE;
            EXECUTE: begin
                if (!op_legal) begin
                    next_state = HALTED;
                end else begin
                    case (op)
                        OP_LASSERT: next_state = WAIT_LOGIC;
                        OP_PYEXEC:  next_state = WAIT_PY;
                        OP_HALT:    next_state = HALTED;
                        default:    next_state = FETCH;
                    endcase
                end
            end
            WAIT_LOGIC: if (logic_ack) next_state = FETCH;
            WAIT_PY:    if (py_ack)    next_state = FETCH;
            HALTED:     next_state = HALTED;
            default:    next_state = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= '0;
            instr          <= '0;
            cert_addr      <= '0;
            error_code     <= '0;
            error_flag     <= 1'b0;
            partition_ops  <= '0;
            mdl_ops        <= '0;
            info_gain      <= '0;
            logic_req      <= 1'b0;
            logic_addr     <= '0;
            py_req         <= 1'b0;
            py_code_addr   <= '0;
            next_module_id <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_file[i] <= '0;
            end
            for (int i = 0; i < MEM_WORDS; i++) begin
                data_mem[i] <= '0;
            end
            for (int i = 0; i < MAX_MODULES; i++) begin
                module_table[i] <= '0;
                for (int j = 0; j < REGION_SLOTS; j++) begin
                    region_table[i][j] <= '0;
                end
            end
        end else begin
            case (state)
                FETCH: instr <= instr_data;
                EXECUTE: begin
                    if (!op_legal) begin
                        // Only the first fault is recorded; pc stays on the offender.
                        if (error_code == '0) begin
                            error_code <= {24'h0, op};
                        end
                        error_flag <= 1'b1;
                    end else begin
                        case (op)
                            OP_XOR_LOAD: begin
                                reg_file[ra] <= data_mem[b];
                                pc <= pc + 32'd4;
                            end
                            OP_XOR_ADD: begin
                                reg_file[ra] <= reg_file[ra] ^ reg_file[rb];
                                pc <= pc + 32'd4;
                            end
                            OP_XOR_SWAP: begin
                                reg_file[ra] <= reg_file[rb];
                                reg_file[rb] <= reg_file[ra];
                                pc <= pc + 32'd4;
                            end
                            OP_XFER: begin
                                reg_file[rb] <= reg_file[ra];
                                pc <= pc + 32'd4;
                            end
                            OP_XOR_RANK: begin
                                reg_file[ra] <= popcount(reg_file[rb]);
                                pc <= pc + 32'd4;
                            end
                            OP_PNEW: begin
                                module_table[mod_idx]    <= 32'd1;
                                region_table[mod_idx][0] <= {24'h0, a};
                                next_module_id <= next_module_id + 7'd1;
                                partition_ops  <= partition_ops + 32'd1;
                                pc <= pc + 32'd4;
                            end
                            OP_MDLACC: begin
                                mdl_ops   <= mdl_ops + 32'd1;
                                info_gain <= info_gain + {24'h0, cost};
                                pc <= pc + 32'd4;
                            end
                            OP_LASSERT: begin
                                logic_addr <= {24'h0, a};
                                logic_req  <= 1'b1;
                            end
                            OP_PYEXEC: begin
                                py_code_addr <= {24'h0, a};
                                py_req       <= 1'b1;
                            end
                            default: pc <= pc + 32'd4;
                        endcase
                    end
                end
                WAIT_LOGIC: begin
                    if (logic_ack) begin
                        cert_addr <= logic_data;
                        logic_req <= 1'b0;
                        pc <= pc + 32'd4;
                    end
                end
                WAIT_PY: begin
                    if (py_ack) begin
                        reg_file[rb] <= py_result;
                        py_req <= 1'b0;
                        pc <= pc + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_thiele_cpu.sv
// Self-checking bench for thiele_cpu: directed scenarios plus random programs
// compared against an instruction-level interpreter of the Thiele ISA.
module tb_thiele_cpu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_data;
    logic [31:0] pc, cert_addr, status, error_code;
    logic [31:0] partition_ops, mdl_ops, info_gain;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_we, mem_en;
    logic [31:0] mem_rdata = '0;
    logic        logic_req;
    logic [31:0] logic_addr;
    logic        logic_ack = 1'b0;
    logic [31:0] logic_data = '0;
    logic        py_req;
    logic [31:0] py_code_addr;
    logic        py_ack = 1'b0;
    logic [31:0] py_result = '0;

    logic [31:0] imem [128];
    assign instr_data = imem[pc[8:2]];

    thiele_cpu dut (
        .clk(clk), .rst(rst), .instr_data(instr_data), .pc(pc),
        .cert_addr(cert_addr), .status(status), .error_code(error_code),
        .partition_ops(partition_ops), .mdl_ops(mdl_ops), .info_gain(info_gain),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_en(mem_en),
        .mem_rdata(mem_rdata), .logic_req(logic_req), .logic_addr(logic_addr),
        .logic_ack(logic_ack), .logic_data(logic_data), .py_req(py_req),
        .py_code_addr(py_code_addr), .py_ack(py_ack), .py_result(py_result)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Engine responders: acknowledge a pending request after ack_delay waiting cycles.
    int          ack_delay = 0;
    logic [31:0] logic_val = '0;
    logic [31:0] py_val = '0;
    int          lcnt = 0;
    int          pcnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (logic_ack) logic_ack = 1'b0;
            else if (logic_req) begin
                if (lcnt >= ack_delay) begin
                    logic_data = logic_val; logic_ack = 1'b1; lcnt = 0;
                end else lcnt++;
            end else lcnt = 0;
            if (py_ack) py_ack = 1'b0;
            else if (py_req) begin
                if (pcnt >= ack_delay) begin
                    py_result = py_val; py_ack = 1'b1; pcnt = 0;
                end else pcnt++;
            end else pcnt = 0;
        end
    end

    // Reference model state
    logic [31:0] m_reg [32];
    logic [31:0] m_mem [256];
    logic [31:0] m_mod [64];
    logic [31:0] m_region0 [64];
    logic [31:0] m_pc, m_cert, m_err, m_part, m_mdl, m_gain, m_status;
    int          m_next;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    endtask

    function automatic logic [31:0] enc(input logic [7:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] c);
        return {op, a, b, c};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 128; i++) imem[i] = 32'hFF000000;
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
    endtask

    // Interprets the program one instruction at a time, straight from the ISA rules.
    task automatic run_model();
        logic [31:0] w, t;
        logic [7:0]  op, a, b, c;
        bit          stop;
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        for (int i = 0; i < 64; i++) begin m_mod[i] = '0; m_region0[i] = '0; end
        m_pc = 0; m_cert = 0; m_err = 0; m_part = 0; m_mdl = 0; m_gain = 0;
        m_next = 0; m_status = 0; stop = 0;
        for (int step = 0; step < 500 && !stop; step++) begin
            w = imem[m_pc[8:2]];
            op = w[31:24]; a = w[23:16]; b = w[15:8]; c = w[7:0];
            case (op)
                8'h0A: m_reg[a % 32] = m_mem[b];
                8'h0B: m_reg[a % 32] = m_reg[a % 32] ^ m_reg[b % 32];
                8'h0C: begin t = m_reg[a % 32]; m_reg[a % 32] = m_reg[b % 32]; m_reg[b % 32] = t; end
                8'h07: m_reg[b % 32] = m_reg[a % 32];
                8'h0D: m_reg[a % 32] = $countones(m_reg[b % 32]);
                8'h05: begin m_mdl++; m_gain = m_gain + c; end
                8'h03: m_cert = logic_val;
                8'h08: m_reg[b % 32] = py_val;
                8'h01: begin
                    if (m_next < 64) begin
                        m_mod[m_next] = 1; m_region0[m_next] = a; m_next++; m_part++;
                    end else stop = 1;
                end
                8'hFF: begin m_pc += 4; m_status = 1; stop = 1; end
                default: stop = 1;
            endcase
            if (stop && m_status == 0) begin
                if (m_err == 0) m_err = op;
                m_status = 3;
            end else if (!stop) m_pc += 4;
        end
    endtask

    // Pulses reset, then preloads data memory before the first fetch edge.
    task automatic applyStimulus();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) dut.data_mem[i] = m_mem[i];
    endtask

    task automatic run_to_halt(input int budget, output int cycles);
        cycles = 0;
        while (status[0] !== 1'b1 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        if (cycles >= budget) checkOutput("halt_timeout", {31'b0, status[0]}, 32'd1);
    endtask

    task automatic compare_all(input string pfx);
        checkOutput({pfx, ".pc"}, pc, m_pc);
        checkOutput({pfx, ".status"}, status, m_status);
        checkOutput({pfx, ".error_code"}, error_code, m_err);
        checkOutput({pfx, ".cert_addr"}, cert_addr, m_cert);
        checkOutput({pfx, ".partition_ops"}, partition_ops, m_part);
        checkOutput({pfx, ".mdl_ops"}, mdl_ops, m_mdl);
        checkOutput({pfx, ".info_gain"}, info_gain, m_gain);
        for (int i = 0; i < 32; i++)
            checkOutput($sformatf("%s.r%0d", pfx, i), dut.reg_file[i], m_reg[i]);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s.mod%0d", pfx, i), dut.module_table[i], m_mod[i]);
            checkOutput($sformatf("%s.region%0d", pfx, i), dut.region_table[i][0], m_region0[i]);
        end
    endtask

    logic [31:0] exp_regs [32];

    initial begin
        int cycles, n;
        logic [7:0] ops [9];
        logic [7:0] op, a, b;

        // Default program
        clear_prog();
        m_mem[0] = 32'h29; m_mem[1] = 32'h12; m_mem[2] = 32'h22; m_mem[3] = 32'h03;
        for (int i = 0; i < 4; i++) imem[i] = enc(8'h0A, 8'(i), 8'(i), 8'h00);
        imem[4] = enc(8'h0B, 8'd3, 8'd0, 8'h00);
        imem[5] = enc(8'h0B, 8'd3, 8'd1, 8'h00);
        imem[6] = enc(8'h0C, 8'd0, 8'd3, 8'h00);
        imem[7] = enc(8'h07, 8'd2, 8'd4, 8'h00);
        imem[8] = enc(8'h0D, 8'd5, 8'd4, 8'h00);
        imem[9] = enc(8'hFF, 8'd0, 8'd0, 8'h00);
        applyStimulus();
        checkOutput("reset.pc", pc, 32'h0);
        checkOutput("reset.status", status, 32'h0);
        run_to_halt(40, cycles);
        checkOutput("default.cycles_le_22", {31'b0, cycles <= 22}, 32'd1);
        for (int i = 0; i < 32; i++) exp_regs[i] = '0;
        exp_regs[0] = 56; exp_regs[1] = 18; exp_regs[2] = 34;
        exp_regs[3] = 41; exp_regs[4] = 34; exp_regs[5] = 2;
        for (int i = 0; i < 32; i++)
            checkOutput($sformatf("default.r%0d", i), dut.reg_file[i], exp_regs[i]);
        checkOutput("default.pc", pc, 32'h28);
        checkOutput("default.status", status, 32'h1);
        checkOutput("default.error_code", error_code, 32'h0);
        checkOutput("default.partition_ops", partition_ops, 32'h0);
        checkOutput("default.mdl_ops", mdl_ops, 32'h0);
        checkOutput("default.info_gain", info_gain, 32'h0);
        repeat (3) @(negedge clk);
        checkOutput("default.pc_frozen", pc, 32'h28);

        // Mid-program reset
        applyStimulus();
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midreset.pc", pc, 32'h0);
        checkOutput("midreset.status", status, 32'h0);
        checkOutput("midreset.r0", dut.reg_file[0], 32'h0);
        checkOutput("midreset.mem0", dut.data_mem[0], 32'h0);

        // LASSERT handshake
        clear_prog();
        imem[0] = enc(8'h03, 8'h10, 8'h00, 8'h00);
        ack_delay = 3; logic_val = 32'hABCD1234;
        applyStimulus();
        n = 0;
        while (!logic_req && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (logic_req && n < 20) begin
            checkOutput("lassert.addr", logic_addr, 32'h10);
            checkOutput("lassert.waiting", {31'b0, status[2]}, 32'd1);
            checkOutput("lassert.pc_hold", pc, 32'h0);
            @(negedge clk); n++;
        end
        checkOutput("lassert.req_cycles", n, 32'(ack_delay + 1));
        checkOutput("lassert.cert", cert_addr, 32'hABCD1234);
        checkOutput("lassert.pc", pc, 32'h4);
        checkOutput("lassert.not_waiting", {31'b0, status[2]}, 32'd0);
        run_to_halt(20, cycles);
        checkOutput("lassert.final_pc", pc, 32'h8);

        // PYEXEC handshake
        clear_prog();
        imem[0] = enc(8'h08, 8'h20, 8'h07, 8'h00);
        ack_delay = 2; py_val = 32'h12345678;
        applyStimulus();
        n = 0;
        while (!py_req && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (py_req && n < 20) begin
            checkOutput("pyexec.addr", py_code_addr, 32'h20);
            checkOutput("pyexec.waiting", {31'b0, status[2]}, 32'd1);
            @(negedge clk); n++;
        end
        checkOutput("pyexec.req_cycles", n, 32'(ack_delay + 1));
        checkOutput("pyexec.r7", dut.reg_file[7], 32'h12345678);
        checkOutput("pyexec.pc", pc, 32'h4);

        // Reset during WAIT_LOGIC
        clear_prog();
        imem[0] = enc(8'h03, 8'h10, 8'h00, 8'h00);
        ack_delay = 1000;
        applyStimulus();
        repeat (4) @(negedge clk);
        checkOutput("waitreset.req_before", {31'b0, logic_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("waitreset.req", {31'b0, logic_req}, 32'd0);
        checkOutput("waitreset.logic_addr", logic_addr, 32'h0);
        checkOutput("waitreset.pc", pc, 32'h0);
        checkOutput("waitreset.status", status, 32'h0);
        checkOutput("waitreset.cert", cert_addr, 32'h0);

        // PNEW / MDLACC accounting
        clear_prog();
        imem[0] = enc(8'h01, 8'h05, 8'h00, 8'h00);
        imem[1] = enc(8'h05, 8'h00, 8'h00, 8'h0A);
        imem[2] = enc(8'h05, 8'h00, 8'h00, 8'h0A);
        applyStimulus();
        run_to_halt(30, cycles);
        checkOutput("pnew.mod0", dut.module_table[0], 32'd1);
        checkOutput("pnew.region0", dut.region_table[0][0], 32'd5);
        checkOutput("pnew.partition_ops", partition_ops, 32'd1);
        checkOutput("pnew.mdl_ops", mdl_ops, 32'd2);
        checkOutput("pnew.info_gain", info_gain, 32'd20);
        checkOutput("pnew.pc", pc, 32'h10);

        // Illegal opcode
        clear_prog();
        imem[0] = enc(8'h07, 8'd0, 8'd1, 8'h00);
        imem[1] = enc(8'h0B, 8'd1, 8'd0, 8'h00);
        imem[2] = 32'h42000000;
        applyStimulus();
        run_to_halt(30, cycles);
        checkOutput("illegal.status", status, 32'h3);
        checkOutput("illegal.error_code", error_code, 32'h42);
        checkOutput("illegal.pc", pc, 32'h8);

        // Module table full
        clear_prog();
        for (int i = 0; i < 65; i++) imem[i] = enc(8'h01, 8'(i), 8'h00, 8'h00);
        applyStimulus();
        run_to_halt(300, cycles);
        checkOutput("full.status", status, 32'h3);
        checkOutput("full.error_code", error_code, 32'h01);
        checkOutput("full.pc", pc, 32'h100);
        checkOutput("full.partition_ops", partition_ops, 32'd64);
        checkOutput("full.mod63", dut.module_table[63], 32'd1);
        checkOutput("full.region63", dut.region_table[63][0], 32'd63);

        // Random programs against the interpreter
        ops = '{8'h0A, 8'h0B, 8'h0C, 8'h07, 8'h0D, 8'h05, 8'h01, 8'h03, 8'h08};
        for (int t = 0; t < 8; t++) begin
            clear_prog();
            for (int i = 0; i < 256; i++) m_mem[i] = $urandom;
            m_mem[255] = 32'hFFFFFFFF;
            m_mem[254] = 32'h0;
            ack_delay = $urandom_range(0, 4);
            logic_val = $urandom;
            py_val = $urandom;
            for (int i = 0; i < 16; i++) begin
                op = ops[$urandom_range(0, 8)];
                a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
                b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
                if (op == 8'h0A && $urandom_range(0, 2) == 0) b = 8'($urandom_range(254, 255));
                imem[i] = enc(op, a, b, 8'($urandom_range(0, 255)));
            end
            run_model();
            applyStimulus();
            run_to_halt(400, cycles);
            compare_all($sformatf("rand%0d", t));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/thiele_cpu.md
Name: thiele_cpu

Overview:
- Small multi-cycle 32-bit CPU core of the Thiele machine.
- Executes XOR-algebra compute ops on an internal register file and data memory, plus partition, MDL and certificate ops with logic-engine and Python-engine handshakes.
- Instruction memory is external, read combinationally at pc.
- Exposes observability counters for the shared Coq/Python/RTL semantics check.

Parameters:
- NUM_REGS, 32, register-file depth (32-bit registers)
- MEM_WORDS, 256, internal data_mem depth (32-bit words)
- MAX_MODULES, 64, module_table entries
- REGION_SLOTS, 16, region_table entries per module

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- instr_data  in  32  instruction word at pc (external memory indexed by pc[31:2])
- pc  out  32  byte program counter
- cert_addr  out  32  last certificate address from the logic engine
- status  out  32  [0] halted, [1] error, [2] waiting on external engine; other bits 0
- error_code  out  32  0 = none; {24'h0, opcode} of the first illegal opcode
- partition_ops, mdl_ops, info_gain  out  32 each  counters
- mem_addr, mem_wdata  out  32; mem_we, mem_en  out  1  legacy port, held 0 in this version
- mem_rdata  in  32  unused
- logic_req  out  1; logic_addr  out  32; logic_ack  in  1; logic_data  in  32
- py_req  out  1; py_code_addr  out  32; py_ack  in  1; py_result  in  32

Behaviour:
- Reset (rst high at a clk edge) clears pc, all outputs, counters, reg_file, data_mem, module_table, region_table and next_module_id, and sets state=FETCH.
- Internal arrays are hierarchically visible under these exact names: reg_file, data_mem, module_table, region_table, state. module_table holds the region size; 0 = empty.
- Instruction fields: op=[31:24], a=[23:16], b=[15:8], cost=[7:0]. Register indices use the low 5 bits; memory indices use 8 bits.
- States: FETCH latches instr_data (1 cycle), then EXECUTE (1 cycle).
- Plain ops take 2 cycles. pc += 4 at the end of EXECUTE or WAIT_* completion, then return to FETCH.
- 0x0A XOR_LOAD: r[a] <= data_mem[b].
- 0x0B XOR_ADD: r[a] <= r[a] ^ r[b].
- 0x0C XOR_SWAP: exchange r[a] and r[b] in the same cycle. a==b is a no-op.
- 0x07 XFER: r[b] <= r[a].
- 0x0D XOR_RANK: r[a] <= popcount(r[b]), range 0..32.
- 0x01 PNEW: if next_module_id < 64:
  - module_table[id] <= 1
  - region_table[id][0] <= a
  - next_module_id++ and partition_ops++
  - Otherwise error (see illegal-op rule).
- 0x05 MDLACC: mdl_ops++, info_gain += cost, with 32-bit wrap.
- 0x03 LASSERT: in EXECUTE, logic_addr <= {24'h0,a} and logic_req <= 1, then go to WAIT_LOGIC.
  - WAIT_LOGIC holds logic_req high until logic_ack is sampled high.
  - On that edge: cert_addr <= logic_data, logic_req <= 0, pc += 4.
- 0x08 PYEXEC: same handshake on py_req/py_code_addr/py_ack. On ack, r[b] <= py_result.
- status[2] = 1 while in WAIT_LOGIC or WAIT_PY. There is no timeout.
- 0xFF HALT: pc += 4, state=HALTED, status[0]=1. HALTED is terminal until reset; pc is frozen.
  - Example: HALT at 0x24 gives a final pc of 0x28.
- Illegal op (any other opcode, or PNEW with the table full):
  - error_code <= {24'h0,op} if error_code==0
  - status[1] <= 1 and state=HALTED; pc is not advanced.
- data_mem can be written hierarchically between reset deassert and the first edge; reset must not be re-applied by the core.
- Reset mid-handshake drops logic_req/py_req in the same edge.

Test Plan:
- Default program with data_mem[0..3]=0x29,0x12,0x22,0x03:
  - Program: XOR_LOAD r0..r3 from m0..m3; XOR_ADD r3,r0; XOR_ADD r3,r1; XOR_SWAP r0,r3; XFER 2->4; XOR_RANK r5,r4; HALT at 0x24.
  - Required: pc=0x28, status=1, error_code=0.
  - Required registers: r0=56, r1=18, r2=34, r3=41, r4=34, r5=2, all other registers 0, all counters 0.
  - Completes in ≤22 cycles.
- LASSERT a=0x10, ack after 3 cycles with logic_data=0xABCD1234:
  - logic_addr=0x10 and logic_req high until the ack edge; status[2]=1 while waiting.
  - cert_addr=0xABCD1234, then pc += 4.
- PYEXEC a=0x20, b=7, py_result=0x12345678 -> r7=0x12345678, py_req dropped on the ack edge.
- PNEW a=5, then MDLACC cost=0x0A twice, then HALT:
  - module_table[0]=1, region_table[0][0]=5.
  - partition_ops=1, mdl_ops=2, info_gain=20.
- Opcode 0x42 at pc 0x8 -> status=0x3, error_code=0x42, pc stays 0x8.
- Assert rst for 1 cycle mid-program and during WAIT_LOGIC -> pc=0, all outputs and counters 0, logic_req=0 on the following cycle.
